// File: rtl/uarc_receiver_arbiter.sv
// UARC receive-side arbiter: round-robin selection of one pending bus request,
// capture into a holding register, valid/ready hand-off to core0, then a
// single-cycle acknowledge back to the originating bus.
module uarc_receiver_arbiter #(
  parameter int unsigned WORD_MAG  = 5,
  parameter int unsigned UARC_SETS = 1,
  localparam int unsigned WORD_WIDTH    = 32'(1) << WORD_MAG,
  localparam int unsigned TOTAL_BUSES   = UARC_SETS * WORD_WIDTH,
  localparam int unsigned BUS_IDX_WIDTH = (TOTAL_BUSES > 1) ? $clog2(TOTAL_BUSES) : 1
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [TOTAL_BUSES-1:0]                  receiver_enable,
  input  logic [TOTAL_BUSES-1:0]                  receiver_kills,
  input  logic [TOTAL_BUSES-1:0]                  receiver_incepts,
  input  logic [TOTAL_BUSES-1:0]                  receiver_sends,
  input  logic [TOTAL_BUSES-1:0]                  receiver_streams,
  input  logic [TOTAL_BUSES-1:0][WORD_WIDTH-1:0]  receiver_datas,
  input  logic [TOTAL_BUSES-1:0][WORD_WIDTH-1:0]  receiver_self_permissions,
  input  logic [TOTAL_BUSES-1:0][WORD_WIDTH-1:0]  receiver_self_addresses,
  input  logic [TOTAL_BUSES-1:0][WORD_WIDTH-1:0]  receiver_incept_permissions,
  input  logic [TOTAL_BUSES-1:0][WORD_WIDTH-1:0]  receiver_incept_addresses,
  output logic [TOTAL_BUSES-1:0]                  receiver_kill_acks,
  output logic [TOTAL_BUSES-1:0]                  receiver_incept_acks,
  output logic [TOTAL_BUSES-1:0]                  receiver_send_acks,
  output logic [TOTAL_BUSES-1:0]                  receiver_stream_acks,
  output logic                                    msg_valid,
  input  logic                                    msg_ready,
  output logic [1:0]                              msg_type,
  output logic [BUS_IDX_WIDTH-1:0]                msg_bus,
  output logic [WORD_WIDTH-1:0]                   msg_data,
  output logic [WORD_WIDTH-1:0]                   msg_self_permission,
  output logic [WORD_WIDTH-1:0]                   msg_self_address,
  output logic [WORD_WIDTH-1:0]                   msg_incept_permission,
  output logic [WORD_WIDTH-1:0]                   msg_incept_address
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HOLD = 2'd1;
  localparam logic [1:0] ACK  = 2'd2;

  localparam logic [1:0] TYPE_KILL   = 2'd0;
  localparam logic [1:0] TYPE_INCEPT = 2'd1;
  localparam logic [1:0] TYPE_SEND   = 2'd2;
  localparam logic [1:0] TYPE_STREAM = 2'd3;

  typedef struct packed {
    logic [WORD_WIDTH-1:0] data;
    logic [WORD_WIDTH-1:0] self_permission;
    logic [WORD_WIDTH-1:0] self_address;
    logic [WORD_WIDTH-1:0] incept_permission;
    logic [WORD_WIDTH-1:0] incept_address;
  } payload_t;

  logic [1:0]                         state_q, state_d;
  logic                               valid_q, valid_d;
  logic [1:0]                         type_q, type_d;
  logic [BUS_IDX_WIDTH-1:0]           bus_q, bus_d;
  payload_t                           payload_q, payload_d;
  logic [3:0][TOTAL_BUSES-1:0]        ack_q, ack_d;
  logic [BUS_IDX_WIDTH-1:0]           rr_ptr_q, rr_ptr_d;

  logic [TOTAL_BUSES-1:0]             eligible;
  logic                               win_found;
  logic [BUS_IDX_WIDTH-1:0]           win_idx;
  logic [1:0]                         win_type;
  int unsigned                        scan;

  // A bus competes when it is enabled and has any request pending
  assign eligible = receiver_enable &
                    (receiver_kills | receiver_incepts | receiver_sends | receiver_streams);

  // Round-robin search starting at rr_ptr, wrapping modulo TOTAL_BUSES
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan      = 0;
    for (int unsigned i = 0; i < TOTAL_BUSES; i++) begin
      scan = 32'(rr_ptr_q) + i;
      if (scan >= TOTAL_BUSES) scan = scan - TOTAL_BUSES;
      if (!win_found && eligible[BUS_IDX_WIDTH'(scan)]) begin
        win_found = 1'b1;
        win_idx   = BUS_IDX_WIDTH'(scan);
      end
    end
  end

  // Highest-priority request type on the winning bus
  always_comb begin
    win_type = TYPE_STREAM;
    if (receiver_kills[win_idx])        win_type = TYPE_KILL;
    else if (receiver_incepts[win_idx]) win_type = TYPE_INCEPT;
    else if (receiver_sends[win_idx])   win_type = TYPE_SEND;
  end

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    type_d    = type_q;
    bus_d     = bus_q;
    payload_d = payload_q;
    ack_d     = '0;
    rr_ptr_d  = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d                     = HOLD;
          valid_d                     = 1'b1;
          type_d                      = win_type;
          bus_d                       = win_idx;
          payload_d.data              = receiver_datas[win_idx];
          payload_d.self_permission   = receiver_self_permissions[win_idx];
          payload_d.self_address      = receiver_self_addresses[win_idx];
          payload_d.incept_permission = receiver_incept_permissions[win_idx];
          payload_d.incept_address    = receiver_incept_addresses[win_idx];
        end
      end
      HOLD: begin
        if (valid_q && msg_ready) begin
          state_d               = ACK;
          valid_d               = 1'b0;
          ack_d[type_q][bus_q]  = 1'b1;
          rr_ptr_d              = (bus_q == BUS_IDX_WIDTH'(TOTAL_BUSES - 1)) ?
                                  '0 : bus_q + BUS_IDX_WIDTH'(1);
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      valid_q   <= 1'b0;
      type_q    <= '0;
      bus_q     <= '0;
      payload_q <= '0;
      ack_q     <= '0;
      rr_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      type_q    <= type_d;
      bus_q     <= bus_d;
      payload_q <= payload_d;
      ack_q     <= ack_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  assign msg_valid             = valid_q;
  assign msg_type              = type_q;
  assign msg_bus               = bus_q;
  assign msg_data              = payload_q.data;
  assign msg_self_permission   = payload_q.self_permission;
  assign msg_self_address      = payload_q.self_address;
  assign msg_incept_permission = payload_q.incept_permission;
  assign msg_incept_address    = payload_q.incept_address;
  assign receiver_kill_acks    = ack_q[TYPE_KILL];
  assign receiver_incept_acks  = ack_q[TYPE_INCEPT];
  assign receiver_send_acks    = ack_q[TYPE_SEND];
  assign receiver_stream_acks  = ack_q[TYPE_STREAM];

endmodule

// File: tb/tb_uarc_receiver_arbiter.sv
// Directed bench for uarc_receiver_arbiter (32 buses, 32-bit words).
module tb_uarc_receiver_arbiter;

  localparam int unsigned NB = 32;
  localparam int unsigned WW = 32;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NB-1:0]          receiver_enable;
  logic [NB-1:0]          receiver_kills, receiver_incepts, receiver_sends, receiver_streams;
  logic [NB-1:0][WW-1:0]  receiver_datas, receiver_self_permissions, receiver_self_addresses;
  logic [NB-1:0][WW-1:0]  receiver_incept_permissions, receiver_incept_addresses;
  logic [NB-1:0]          receiver_kill_acks, receiver_incept_acks;
  logic [NB-1:0]          receiver_send_acks, receiver_stream_acks;
  logic                   msg_valid;
  logic                   msg_ready;
  logic [1:0]             msg_type;
  logic [4:0]             msg_bus;
  logic [WW-1:0]          msg_data, msg_self_permission, msg_self_address;
  logic [WW-1:0]          msg_incept_permission, msg_incept_address;

  int n_checks = 0;
  int n_errors = 0;

  uarc_receiver_arbiter #(.WORD_MAG(5), .UARC_SETS(1)) dut (
    .clk                         (clk),
    .reset                       (reset),
    .receiver_enable             (receiver_enable),
    .receiver_kills              (receiver_kills),
    .receiver_incepts            (receiver_incepts),
    .receiver_sends              (receiver_sends),
    .receiver_streams            (receiver_streams),
    .receiver_datas              (receiver_datas),
    .receiver_self_permissions   (receiver_self_permissions),
    .receiver_self_addresses     (receiver_self_addresses),
    .receiver_incept_permissions (receiver_incept_permissions),
    .receiver_incept_addresses   (receiver_incept_addresses),
    .receiver_kill_acks          (receiver_kill_acks),
    .receiver_incept_acks        (receiver_incept_acks),
    .receiver_send_acks          (receiver_send_acks),
    .receiver_stream_acks        (receiver_stream_acks),
    .msg_valid                   (msg_valid),
    .msg_ready                   (msg_ready),
    .msg_type                    (msg_type),
    .msg_bus                     (msg_bus),
    .msg_data                    (msg_data),
    .msg_self_permission         (msg_self_permission),
    .msg_self_address            (msg_self_address),
    .msg_incept_permission       (msg_incept_permission),
    .msg_incept_address          (msg_incept_address)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] all_acks();
    return {receiver_stream_acks, receiver_send_acks, receiver_incept_acks, receiver_kill_acks};
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    for (int k = 0; k < 8; k++) begin
      if (msg_valid) break;
      step();
    end
    check({tag, "_valid"}, 128'(msg_valid), 128'(1));
  endtask

  task automatic clear_req(input int t, input int b);
    case (t)
      0: receiver_kills[b]   = 1'b0;
      1: receiver_incepts[b] = 1'b0;
      2: receiver_sends[b]   = 1'b0;
      default: receiver_streams[b] = 1'b0;
    endcase
  endtask

  // Expect message (t,b,data) in HOLD, accept it, check the ack pulse,
  // drop the request in the ack cycle, optionally re-raise it once idle.
  task automatic deliver(input string tag, input int t, input int b,
                         input logic [WW-1:0] data, input bit reraise);
    logic [127:0] exp_ack;
    wait_valid(tag);
    check({tag, "_type"}, 128'(msg_type), 128'(t));
    check({tag, "_bus"},  128'(msg_bus),  128'(b));
    check({tag, "_data"}, 128'(msg_data), 128'(data));
    msg_ready = 1'b1;
    step();
    exp_ack = 128'(1) << (t * 32 + b);
    check({tag, "_ack"}, all_acks(), exp_ack);
    check({tag, "_valid_in_ack"}, 128'(msg_valid), 128'(0));
    clear_req(t, b);
    step();
    check({tag, "_ack_one_cycle"}, all_acks(), 128'(0));
    if (reraise) receiver_sends[b] = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    msg_ready = 1'b0;
    receiver_enable = '1;
    receiver_kills = '0; receiver_incepts = '0; receiver_sends = '0; receiver_streams = '0;
    receiver_datas = '0; receiver_self_permissions = '0; receiver_self_addresses = '0;
    receiver_incept_permissions = '0; receiver_incept_addresses = '0;
    for (int b = 0; b < NB; b++) receiver_datas[b] = 32'hA000_0000 + 32'(b);

    // Reset state
    step(); step();
    check("rst_valid", 128'(msg_valid), 128'(0));
    check("rst_acks",  all_acks(),      128'(0));
    check("rst_type",  128'(msg_type),  128'(0));
    check("rst_bus",   128'(msg_bus),   128'(0));
    check("rst_data",  128'(msg_data),  128'(0));
    reset = 1'b0;
    step();
    check("idle_no_req", 128'(msg_valid), 128'(0));

    // Round-robin fairness with wrap 31 -> 0
    receiver_sends[0] = 1'b1; receiver_sends[1] = 1'b1; receiver_sends[31] = 1'b1;
    deliver("rr0a",  2, 0,  32'hA000_0000, 1'b1);
    deliver("rr1a",  2, 1,  32'hA000_0001, 1'b1);
    deliver("rr31a", 2, 31, 32'hA000_001F, 1'b1);
    deliver("rr0b",  2, 0,  32'hA000_0000, 1'b0);
    deliver("rr1b",  2, 1,  32'hA000_0001, 1'b0);
    deliver("rr31b", 2, 31, 32'hA000_001F, 1'b0);
    msg_ready = 1'b0;
    step();
    check("rr_drained", 128'(msg_valid), 128'(0));

    // Single send on bus 3 with full payload
    receiver_datas[3] = 32'hDEAD_BEEF;
    receiver_self_permissions[3] = 32'h1111_0003;
    receiver_self_addresses[3] = 32'h2222_0003;
    receiver_incept_permissions[3] = 32'h3333_0003;
    receiver_incept_addresses[3] = 32'h4444_0003;
    receiver_sends[3] = 1'b1;
    msg_ready = 1'b1;
    step();
    check("s1_latency", 128'(msg_valid), 128'(1));
    check("s1_sperm", 128'(msg_self_permission), 128'(32'h1111_0003));
    check("s1_saddr", 128'(msg_self_address), 128'(32'h2222_0003));
    check("s1_iperm", 128'(msg_incept_permission), 128'(32'h3333_0003));
    check("s1_iaddr", 128'(msg_incept_address), 128'(32'h4444_0003));
    deliver("s1", 2, 3, 32'hDEAD_BEEF, 1'b0);

    // Type priority on bus 5: kill, then send, then stream
    receiver_kills[5] = 1'b1; receiver_sends[5] = 1'b1; receiver_streams[5] = 1'b1;
    deliver("pri_kill",   0, 5, 32'hA000_0005, 1'b0);
    deliver("pri_send",   2, 5, 32'hA000_0005, 1'b0);
    deliver("pri_stream", 3, 5, 32'hA000_0005, 1'b0);

    // Backpressure: payload held while the source changes, no ack
    msg_ready = 1'b0;
    receiver_datas[10] = 32'h1111_2222;
    receiver_sends[10] = 1'b1;
    wait_valid("bp");
    for (int k = 0; k < 10; k++) begin
      receiver_datas[10] = 32'h3333_0000 + 32'(k);
      step();
      check("bp_valid_held", 128'(msg_valid), 128'(1));
      check("bp_data_held",  128'(msg_data),  128'(32'h1111_2222));
      check("bp_no_ack",     all_acks(),      128'(0));
    end
    deliver("bp", 2, 10, 32'h1111_2222, 1'b0);

    // Disabled bus is ignored until enabled
    msg_ready = 1'b1;
    receiver_enable[7] = 1'b0;
    receiver_incepts[7] = 1'b1;
    receiver_datas[7] = 32'h0777_0777;
    for (int k = 0; k < 5; k++) begin
      step();
      check("dis_no_valid", 128'(msg_valid), 128'(0));
      check("dis_no_ack",   all_acks(),      128'(0));
    end
    receiver_enable[7] = 1'b1;
    deliver("dis_en", 1, 7, 32'h0777_0777, 1'b0);

    // Reset mid-HOLD: pointer is at 8, so bus 20 wins before bus 2
    msg_ready = 1'b0;
    receiver_streams[2] = 1'b1;
    receiver_streams[20] = 1'b1;
    wait_valid("rh");
    check("rh_bus_pre", 128'(msg_bus), 128'(20));
    #2;
    reset = 1'b1;
    #1;
    check("rh_async_valid", 128'(msg_valid), 128'(0));
    check("rh_async_acks",  all_acks(),      128'(0));
    step();
    reset = 1'b0;
    deliver("rh_bus2",  3, 2,  32'hA000_0002, 1'b0);
    deliver("rh_bus20", 3, 20, 32'hA000_0014, 1'b0);
    step();
    check("end_idle", 128'(msg_valid), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uarc_receiver_arbiter.md
# uarc_receiver_arbiter

Upstream stage of core0 on the UARC receive side. Each cycle it scans all `TOTAL_BUSES` incoming UARC buses for pending kill/incept/send/stream requests and selects one by round-robin. It captures the winning bus's payload into a holding register and presents it to core0 through a valid/ready handshake. Once core0 accepts the message, it returns a one-cycle acknowledge on the matching per-bus ack line.

## Interface
- `WORD_MAG`, 5, log2 of word width; `WORD_WIDTH = 1 << WORD_MAG`
- `UARC_SETS`, 1, bus sets; `TOTAL_BUSES = UARC_SETS * WORD_WIDTH`
- `BUS_IDX_WIDTH` (localparam), `max(1, $clog2(TOTAL_BUSES))`

Ports:
- `clk` in 1: single clock, all state on rising edge
- `reset` in 1: asynchronous, active-high; clears all state
- `receiver_enable` in TOTAL_BUSES: bus connected/enabled
- `receiver_kills`, `receiver_incepts`, `receiver_sends`, `receiver_streams` in TOTAL_BUSES each: level requests, held until acked
- `receiver_datas`, `receiver_self_permissions`, `receiver_self_addresses`, `receiver_incept_permissions`, `receiver_incept_addresses` in [TOTAL_BUSES][WORD_WIDTH]: per-bus payload
- `receiver_kill_acks`, `receiver_incept_acks`, `receiver_send_acks`, `receiver_stream_acks` out TOTAL_BUSES each: one-cycle ack pulses
- `msg_valid` out 1: captured message available to core0
- `msg_ready` in 1: core0 accepts when high with `msg_valid`
- `msg_type` out 2: 0 kill, 1 incept, 2 send, 3 stream
- `msg_bus` out BUS_IDX_WIDTH: index of the source bus
- `msg_data`, `msg_self_permission`, `msg_self_address`, `msg_incept_permission`, `msg_incept_address` out WORD_WIDTH each: captured payload

## Operation
- Eligible bus i: `receiver_enable[i]` and any of its four requests high.
- Type priority within a bus: kill > incept > send > stream. Only the highest-priority type is captured per grant.
- Round-robin across buses:
  - Pointer `rr_ptr` (BUS_IDX_WIDTH bits, reset 0) names the highest-priority bus.
  - Search runs `rr_ptr`, `rr_ptr+1`, … and wraps modulo TOTAL_BUSES.
  - On accept, `rr_ptr` becomes winner+1, wrapping to 0 after TOTAL_BUSES-1.
- FSM states:
  - IDLE: if any eligible bus, capture winner index, type and all five payload words; go to HOLD. Otherwise stay in IDLE.
  - HOLD: `msg_valid`=1 and the outputs are stable. On `msg_valid && msg_ready`, go to ACK; otherwise stay in HOLD.
  - ACK: exactly one ack bit high (the bit for the captured type and bus). `msg_valid`=0. Go to IDLE unconditionally.
- Request withdrawal or enable drop while in HOLD: the captured message is still delivered and acked. No abort.
- Requests on non-winning buses are never acked and stay pending.
- Reset values (asynchronous): state IDLE, `msg_valid`=0, all acks 0, `msg_type`=0, `msg_bus`=0, all payload outputs 0, `rr_ptr`=0.
- Reset asserted mid-HOLD or mid-ACK drops the message and the pending ack. The sender keeps its request and is re-granted after reset.

## Timing
- Request sampled in IDLE at edge n → `msg_valid` high from cycle n+1.
- Accept at edge m → ack high during cycle m+1 only → IDLE at m+2 → earliest next `msg_valid` at m+3.
- Peak throughput: 1 message per 3 cycles.
- A sender must drop the acked request within the ack cycle. It is not resampled until the IDLE cycle after the ack.
- Payload outputs change only on entry to HOLD. They are registered, with no combinational path from `receiver_*` to `msg_*`.
- Acks are registered, with no combinational path from `msg_ready` to the acks.
- `msg_ready` is ignored outside HOLD.

## Test plan
- Single send: bus 3 `send`=1, data 0xDEADBEEF, enable 1, `msg_ready`=1. Required: `msg_valid` 1 cycle later with type 2, bus 3, data 0xDEADBEEF; `receiver_send_acks[3]` pulses for exactly one cycle the cycle after accept.
- Priority: bus 5 has kill, send and stream all high. Required: type 0 delivered and only `receiver_kill_acks[5]` pulses. Send then stream follow on later grants while held.
- Round-robin fairness: buses 0, 1 and 31 request send continuously; drop each request after its ack and re-raise it. Required grant order 0, 1, 31, 0, 1, 31…, with `rr_ptr` wrapping 31→0.
- Backpressure: `msg_ready`=0 for 10 cycles while in HOLD and the bus payload changes. Required: `msg_valid` stays high, captured payload is unchanged, no ack; ack comes 1 cycle after `msg_ready` rises.
- Disabled bus: bus 7 `incept`=1 with `receiver_enable[7]`=0. Required: no `msg_valid`, no ack. Enabling it yields type 1, bus 7.
- Reset mid-HOLD: assert `reset` while `msg_valid`=1. Required: `msg_valid` and all acks go to 0 asynchronously. After release, the still-held request is re-delivered with `rr_ptr` starting from 0.
